// File: rtl/dac_writer.sv
// SPI mode-0 transmitter for a serial DAC: latches {channel, CTRL, code} on go, shifts it
// MSB-first under cs, then strobes ldac_n to update the DAC output.
module dac_writer #(
    parameter int unsigned DATA_BITS   = 12,
    parameter logic [1:0]  CTRL        = 2'b01,
    parameter int unsigned HALF_PERIOD = 8
) (
    input  logic                 clkin,
    input  logic                 rst,
    input  logic                 go,
    input  logic [1:0]           channel,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 state,
    output logic                 done,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs,
    output logic                 ldac_n
);

    localparam int unsigned FrameBits = 4 + DATA_BITS;
    localparam int unsigned CntW      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned BitW      = $clog2(FrameBits);
    localparam logic [CntW-1:0] CntLoad = CntW'(HALF_PERIOD - 1);
    localparam logic [BitW-1:0] BitLoad = BitW'(FrameBits - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StSclkLo, StSclkHi, StHold, StLdac} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [FrameBits-1:0] sr_q, sr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 ldac_q, ldac_d;
    logic                 cnt_last;

    assign cnt_last = (cnt_q == '0);

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_last ? CntLoad : cnt_q - 1'b1;
        bit_d  = bit_q;
        sr_d   = sr_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_d   = cs_q;
        ldac_d = ldac_q;
        unique case (fsm_q)
            StIdle: begin
                cnt_d = CntLoad;
                if (go) begin
                    fsm_d  = StSetup;
                    busy_d = 1'b1;
                    cs_d   = 1'b0;
                    sr_d   = {channel, CTRL, data_i};
                    mosi_d = channel[1];
                    bit_d  = BitLoad;
                end else begin
                    cs_d   = 1'b1;
                    sclk_d = 1'b0;
                    ldac_d = 1'b1;
                end
            end
            StSetup: if (cnt_last) fsm_d = StSclkLo;
            StSclkLo: begin
                if (cnt_last) begin
                    sclk_d = 1'b1;
                    fsm_d  = StSclkHi;
                end
            end
            StSclkHi: begin
                if (cnt_last) begin
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        fsm_d  = StHold;
                        mosi_d = 1'b0;
                    end else begin
                        // Next bit changes on the same edge as the sclk fall.
                        bit_d  = bit_q - 1'b1;
                        sr_d   = sr_q << 1;
                        mosi_d = sr_q[FrameBits-2];
                        fsm_d  = StSclkLo;
                    end
                end
            end
            StHold: begin
                if (cnt_last) begin
                    cs_d   = 1'b1;
                    ldac_d = 1'b0;
                    fsm_d  = StLdac;
                end
            end
            StLdac: begin
                if (cnt_last) begin
                    ldac_d = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            fsm_q  <= StIdle;
            cnt_q  <= CntLoad;
            bit_q  <= '0;
            sr_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q   <= 1'b1;
            ldac_q <= 1'b1;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sr_q   <= sr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_q   <= cs_d;
            ldac_q <= ldac_d;
        end
    end

    assign state  = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign cs     = cs_q;
    assign ldac_n = ldac_q;

endmodule

// File: tb/tb_dac_writer.sv
// Bench for dac_writer: a negedge monitor reassembles each SPI frame and checks it against
// a queue of expected frames; the main process drives transfers and checks timing.
module tb_dac_writer;

    logic        clkin = 1'b0;
    logic        rst, go, state, done, sclk, mosi, cs, ldac_n;
    logic [1:0]  channel;
    logic [11:0] data_i;

    logic        rst_b, go_b, state_b, done_b, sclk_b, mosi_b, cs_b, ldac_n_b;
    logic [1:0]  channel_b;
    logic [11:0] data_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clkin = ~clkin;

    dac_writer #(.DATA_BITS(12), .CTRL(2'b01), .HALF_PERIOD(8)) dut (
        .clkin(clkin), .rst(rst), .go(go), .channel(channel), .data_i(data_i),
        .state(state), .done(done), .sclk(sclk), .mosi(mosi), .cs(cs), .ldac_n(ldac_n)
    );

    dac_writer #(.DATA_BITS(12), .CTRL(2'b01), .HALF_PERIOD(1)) dut_fast (
        .clkin(clkin), .rst(rst_b), .go(go_b), .channel(channel_b), .data_i(data_b),
        .state(state_b), .done(done_b), .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b),
        .ldac_n(ldac_n_b)
    );

    function automatic void check(input string nm, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Frame monitor for the HALF_PERIOD=8 instance; a reset aborts the frame without a pop.
    logic        in_frame = 1'b0;
    logic        sclk_prev = 1'b0;
    logic [15:0] mon_sr;
    int          mon_bits;
    logic [15:0] mon_exp;

    always @(negedge clkin) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!cs && !in_frame) begin
                in_frame = 1'b1;
                mon_bits = 0;
                mon_sr   = '0;
            end
            if (in_frame && sclk && !sclk_prev) begin
                mon_sr = {mon_sr[14:0], mosi};
                mon_bits++;
            end
            if (in_frame && cs) begin
                in_frame = 1'b0;
                check("frame_bits", mon_bits, 16);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_data", {16'h0, mon_sr}, {16'h0, mon_exp});
                end
            end
        end
        sclk_prev = sclk;
    end

    task automatic xfer(input logic [1:0] ch, input logic [11:0] d, input bit poke,
                        output int lat, output int cs_lo, output int ld_lo,
                        output int ld_first, output int idle_seen);
        channel = ch;
        data_i  = d;
        go      = 1'b1;
        exp_q.push_back({ch, 2'b01, d});
        tick();
        go        = 1'b0;
        lat       = -1;
        cs_lo     = 0;
        ld_lo     = 0;
        ld_first  = -1;
        idle_seen = 0;
        for (int n = 0; n < 1000; n++) begin
            if (n > 0) tick();
            if (done) begin
                lat = n;
                break;
            end
            if (!cs) cs_lo++;
            if (!ldac_n) begin
                ld_lo++;
                if (ld_first < 0) ld_first = n;
            end
            if (!state) idle_seen++;
            if (n == 1) begin
                channel = ~ch;
                data_i  = ~d;
            end
            if (poke && n == 50) go = 1'b1;
            if (poke && n == 51) go = 1'b0;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 1000; n++) begin
            if (n > 0) tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat, cs_lo, ld_lo, ld_first, idle_seen, extra, gap, rises;
    int tog, first_rise, last_fall;
    logic        prev_b, last_bit;
    logic [15:0] fr_b;

    initial begin
        rst = 1'b1; go = 1'b0; channel = '0; data_i = '0;
        rst_b = 1'b1; go_b = 1'b0; channel_b = '0; data_b = '0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_done", done, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs", cs, 1);
        check("rst_ldac", ldac_n, 1);
        rst = 1'b0; rst_b = 1'b0;
        repeat (2) tick();

        // Single write
        xfer(2'b10, 12'hA5C, 1'b0, lat, cs_lo, ld_lo, ld_first, idle_seen);
        check("single_latency", lat, 280);
        check("single_cs_low", cs_lo, 272);
        check("single_ldac_len", ld_lo, 8);
        check("single_ldac_start", ld_first, 272);
        tick();
        check("single_done_pulse", done, 0);
        check("single_idle", state, 0);
        repeat (5) tick();

        // Busy rejection
        xfer(2'b01, 12'h3C7, 1'b1, lat, cs_lo, ld_lo, ld_first, idle_seen);
        check("busy_latency", lat, 280);
        check("busy_state_held", idle_seen, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || state || !cs) extra++;
        end
        check("busy_not_queued", extra, 0);

        // Back-to-back with go held
        channel = 2'b01; data_i = 12'h000; go = 1'b1;
        exp_q.push_back(16'h5000);
        exp_q.push_back(16'hDFFF);
        tick();
        channel = 2'b11; data_i = 12'hFFF;
        wait_done(lat);
        check("b2b_latency1", lat, 280);
        gap = -1;
        for (int n = 1; n < 10; n++) begin
            tick();
            if (!cs) begin
                gap = n;
                break;
            end
        end
        go = 1'b0;
        check("b2b_cs_gap", gap, 1);
        wait_done(lat);
        check("b2b_latency2", lat, 280);
        repeat (5) tick();

        // Reset during the 7th SCLK_HI
        channel = 2'b01; data_i = 12'h3C3; go = 1'b1;
        tick();
        go = 1'b0;
        rises = 0;
        prev_b = sclk;
        for (int n = 0; n < 1000 && rises < 7; n++) begin
            tick();
            if (sclk && !prev_b) rises++;
            prev_b = sclk;
        end
        check("abort_reached_7", rises, 7);
        tick();
        rst = 1'b1;
        tick();
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_ldac", ldac_n, 1);
        check("abort_state", state, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || !ldac_n) extra++;
        end
        check("abort_no_done", extra, 0);
        xfer(2'b11, 12'h7E1, 1'b0, lat, cs_lo, ld_lo, ld_first, idle_seen);
        check("after_abort_latency", lat, 280);
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);

        // HALF_PERIOD=1 instance
        channel_b = 2'b00; data_b = 12'h001; go_b = 1'b1;
        tick();
        go_b = 1'b0;
        lat = -1; tog = 0; rises = 0; first_rise = -1; last_fall = -1;
        prev_b = 1'b0; last_bit = 1'b0; fr_b = '0;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) tick();
            if (done_b) begin
                lat = n;
                break;
            end
            if (sclk_b != prev_b) tog++;
            if (sclk_b && !prev_b) begin
                rises++;
                fr_b = {fr_b[14:0], mosi_b};
                last_bit = mosi_b;
                if (first_rise < 0) first_rise = n;
            end
            if (!sclk_b && prev_b) last_fall = n;
            prev_b = sclk_b;
        end
        check("fast_latency", lat, 35);
        check("fast_rises", rises, 16);
        check("fast_toggles", tog, 32);
        check("fast_toggle_span", last_fall - first_rise, 31);
        check("fast_frame", {16'h0, fr_b}, 32'h1001);
        check("fast_last_bit", last_bit, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
